// File: rtl/xnor_adder_pkg.sv
// Full-adder cell models shared by the chunk adders and the error-flag reference.
// The XNOR cell keeps an exact carry and derives sum as its complement.
package xnor_adder_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Returns {cout, sum}; the sum is wrong only for (a,b,cin) = 000 and 111.
  function automatic logic [1:0] xnor_fa_approx(input logic a, input logic b, input logic cin);
    logic x;
    logic cout;
    x    = a ~^ b;
    cout = x ? a : cin;
    return {cout, ~cout};
  endfunction

  function automatic logic [1:0] fa_exact(input logic a, input logic b, input logic cin);
    logic cout;
    logic sum;
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
    return {cout, sum};
  endfunction

endpackage

// File: rtl/xnor_adder_chunk.sv
// One CHUNK-bit ripple segment; bits whose global index is below APPROX_BITS
// use the XNOR cell while mode is set, all others use the exact cell.
module xnor_adder_chunk
  import xnor_adder_pkg::*;
#(
  parameter int LSB         = 0,
  parameter int CHUNK       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  always_comb begin : p_ripple
    logic       c;
    logic [1:0] r;
    c   = cin;
    r   = '0;
    sum = '0;
    for (int j = 0; j < CHUNK; j++) begin
      if (((LSB + j) < APPROX_BITS) && mode) r = xnor_fa_approx(a[j], b[j], c);
      else                                    r = fa_exact(a[j], b[j], c);
      sum[j] = r[0];
      c      = r[1];
    end
    cout = c;
  end

endmodule

// File: rtl/xnor_approx_adder_pipe.sv
// Pipelined WIDTH-bit adder with optional XNOR-approximate LSBs, valid/ready
// on both sides and a saturating count of approximate results that were wrong.
module xnor_approx_adder_pipe
  import xnor_adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4,
  parameter int STAGES      = 2,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     add1_i,
  input  logic [WIDTH-1:0]     add2_i,
  input  logic                 mode_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH:0]       result_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 clear_i
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_stages
    $error("STAGES must be 1..WIDTH and divide WIDTH");
  end
  if ((APPROX_BITS < 0) || (APPROX_BITS > WIDTH)) begin : g_bad_approx
    $error("APPROX_BITS must be 0..WIDTH");
  end

  // Handshake: a transfer happens on a side exactly when its valid and ready are
  // both high at the rising edge; an offered output holds until it is taken.
  logic [STAGES-1:0]            v_q, carry_q, mode_q, flag_q, adv;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, sum_q;
  logic                         flag0;

  // A stage stalls only when it and every stage after it are full and the
  // output is blocked, so bubbles anywhere in the pipe are absorbed.
  always_comb begin : p_adv
    logic all_full;
    all_full = 1'b1;
    adv      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full = all_full & v_q[k];
      adv[k]   = ready_i | ~all_full;
    end
  end

  // Approximate vs exact reference over the low bits, evaluated on the operands.
  always_comb begin : p_flag
    logic       ca, ce, diff;
    logic [1:0] ra, re;
    ca   = 1'b0;
    ce   = 1'b0;
    diff = 1'b0;
    ra   = '0;
    re   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < APPROX_BITS) begin
        ra   = xnor_fa_approx(add1_i[i], add2_i[i], ca);
        re   = fa_exact(add1_i[i], add2_i[i], ce);
        diff = diff | (ra[0] ^ re[0]);
        ca   = ra[1];
        ce   = re[1];
      end
    end
    flag0 = mode_i & (diff | (ca ^ ce));
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, sum_in, sum_next, a_r, b_r, sum_r;
    logic [CHUNK-1:0] s_c;
    logic             v_in, c_in, m_in, f_in, cout_c;
    logic             v_r, c_r, m_r, f_r;

    if (k == 0) begin : g_first
      assign a_in   = add1_i;
      assign b_in   = add2_i;
      assign sum_in = '0;
      assign c_in   = 1'b0;
      assign m_in   = mode_i;
      assign v_in   = valid_i;
      assign f_in   = flag0;
    end else begin : g_rest
      assign a_in   = a_q[k-1];
      assign b_in   = b_q[k-1];
      assign sum_in = sum_q[k-1];
      assign c_in   = carry_q[k-1];
      assign m_in   = mode_q[k-1];
      assign v_in   = v_q[k-1];
      assign f_in   = flag_q[k-1];
    end

    xnor_adder_chunk #(
      .LSB        (k * CHUNK),
      .CHUNK      (CHUNK),
      .APPROX_BITS(APPROX_BITS)
    ) u_chunk (
      .a   (a_in[k*CHUNK +: CHUNK]),
      .b   (b_in[k*CHUNK +: CHUNK]),
      .cin (c_in),
      .mode(m_in),
      .sum (s_c),
      .cout(cout_c)
    );

    always_comb begin
      sum_next                     = sum_in;
      sum_next[k*CHUNK +: CHUNK]   = s_c;
    end

    // Payload loads only with valid data so the output holds its last value.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        v_r   <= 1'b0;
        a_r   <= '0;
        b_r   <= '0;
        sum_r <= '0;
        c_r   <= 1'b0;
        m_r   <= 1'b0;
        f_r   <= 1'b0;
      end else if (adv[k]) begin
        v_r <= v_in;
        if (v_in) begin
          a_r   <= a_in;
          b_r   <= b_in;
          sum_r <= sum_next;
          c_r   <= cout_c;
          m_r   <= m_in;
          f_r   <= f_in;
        end
      end
    end

    assign v_q[k]     = v_r;
    assign a_q[k]     = a_r;
    assign b_q[k]     = b_r;
    assign sum_q[k]   = sum_r;
    assign carry_q[k] = c_r;
    assign mode_q[k]  = m_r;
    assign flag_q[k]  = f_r;
  end

  assign ready_o  = adv[0];
  assign valid_o  = v_q[STAGES-1];
  assign result_o = {carry_q[STAGES-1], sum_q[STAGES-1]};

  logic unused_last_stage;
  assign unused_last_stage = ^{a_q[STAGES-1], b_q[STAGES-1], mode_q[STAGES-1]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
    end else if (clear_i) begin
      err_cnt_o <= '0;
    end else if (valid_o && ready_i && flag_q[STAGES-1] && !(&err_cnt_o)) begin
      err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xnor_approx_adder_pipe.sv
// Bench for xnor_approx_adder_pipe at WIDTH=16, APPROX_BITS=4, STAGES=2:
// directed vectors, streaming, backpressure, counter saturation/clear, async reset.
module tb_xnor_approx_adder_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, ready_o, mode_i, valid_o, ready_i, clear_i;
  logic [15:0] add1_i, add2_i, err_cnt_o;
  logic [16:0] result_o;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  // Entry = {flag, result}.
  logic [17:0] exp_q[$];
  logic [15:0] exp_cnt = '0;
  logic [17:0] mon_e;
  logic        mon_f, mon_x;

  xnor_approx_adder_pipe #(
    .WIDTH(16), .APPROX_BITS(4), .STAGES(2), .ERR_CNT_W(16)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .add1_i   (add1_i),
    .add2_i   (add2_i),
    .mode_i   (mode_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .err_cnt_o(err_cnt_o),
    .clear_i  (clear_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference: exact sum, then flip low-bit sums where a, b and carry-in agree.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic m);
    logic [16:0] ex, r;
    logic [15:0] cin_v;
    logic        f;
    ex    = {1'b0, a} + {1'b0, b};
    cin_v = a ^ b ^ ex[15:0];
    r     = ex;
    f     = 1'b0;
    if (m) begin
      for (int i = 0; i < 4; i++) begin
        if ((a[i] == b[i]) && (b[i] == cin_v[i])) begin
          r[i] = ~r[i];
          f    = 1'b1;
        end
      end
    end
    return {f, r};
  endfunction

  // Output monitor: pops expected results and tracks the expected counter.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      checks++;
      if (err_cnt_o !== exp_cnt) begin
        errors++;
        $display("FAIL err_cnt_track got=%h exp=%h t=%0t", err_cnt_o, exp_cnt, $time);
      end
      mon_x = valid_o && ready_i;
      mon_f = 1'b0;
      if (mon_x) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h exp=none t=%0t", result_o, $time);
        end else begin
          mon_e = exp_q.pop_front();
          mon_f = mon_e[17];
          n_out++;
          if (result_o !== mon_e[16:0]) begin
            errors++;
            $display("FAIL result got=%h exp=%h t=%0t", result_o, mon_e[16:0], $time);
          end
        end
      end
      if (clear_i) exp_cnt = '0;
      else if (mon_x && mon_f && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic m, input logic [17:0] e);
    int budget;
    budget  = 0;
    valid_i = 1'b1;
    add1_i  = a;
    add2_i  = b;
    mode_i  = m;
    @(negedge clk_i);
    while (!ready_o && budget < 50) begin
      @(negedge clk_i);
      budget++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=ready_o=0 exp=ready_o=1");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk_i);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    @(posedge clk_i); #1;
  endtask

  task automatic check_cnt(input string name, input logic [15:0] e);
    @(negedge clk_i);
    checks++;
    if (err_cnt_o !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, err_cnt_o, e);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clear_i = 1'b0;
    add1_i = '0; add2_i = '0; mode_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checks += 4;
    if (valid_o !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    if (ready_o !== 1'b1)   begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    if (result_o !== 17'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result_o); end
    if (err_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", err_cnt_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_vectors();
    ready_i = 1'b1;
    send(16'h0000, 16'h0000, 1'b1, {1'b1, 17'h0000F});
    valid_i = 1'b0; wait_drain(); check_cnt("cnt_zero_approx", 16'd1);
    send(16'h0000, 16'h0000, 1'b0, {1'b0, 17'h00000});
    valid_i = 1'b0; wait_drain(); check_cnt("cnt_zero_exact", 16'd1);
    send(16'hFFFF, 16'h0001, 1'b1, {1'b0, 17'h10000});
    valid_i = 1'b0; wait_drain(); check_cnt("cnt_ffff_plus_1", 16'd1);
    send(16'h0F0F, 16'h0F0F, 1'b1, {1'b1, 17'h01E10});
    valid_i = 1'b0; wait_drain(); check_cnt("cnt_0f0f", 16'd2);
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic        m;
    ready_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      m = 1'($urandom_range(0, 1));
      send(a, b, m, model(a, b, m));
      if ($urandom_range(0, 2) == 0) begin
        valid_i = 1'b0;
        @(posedge clk_i); #1;
      end
    end
    valid_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    int          start;
    start   = n_out;
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      valid_i = 1'b1; add1_i = a; add2_i = b; mode_i = 1'b1;
      exp_q.push_back(model(a, b, 1'b1));
      @(negedge clk_i);
      checks += 2;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1 i=%0d", ready_o, i); end
      if (valid_o !== (i >= 2)) begin errors++; $display("FAIL b2b_latency got=%b exp=%b i=%0d", valid_o, (i >= 2), i); end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      checks++;
      if (valid_o !== (k < 2)) begin errors++; $display("FAIL b2b_tail got=%b exp=%b k=%0d", valid_o, (k < 2), k); end
      @(posedge clk_i); #1;
    end
    wait_drain();
    checks++;
    if ((n_out - start) != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", n_out - start); end
  endtask

  task automatic test_stall();
    logic [17:0] e0;
    e0 = model(16'h1234, 16'h0F0F, 1'b1);
    ready_i = 1'b0;
    send(16'h1234, 16'h0F0F, 1'b1, e0);
    send(16'hABCD, 16'h1111, 1'b0, model(16'hABCD, 16'h1111, 1'b0));
    valid_i = 1'b1; add1_i = 16'h7777; add2_i = 16'h8889; mode_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      checks += 3;
      if (ready_o !== 1'b0)        begin errors++; $display("FAIL stall_ready got=%b exp=0 c=%0d", ready_o, c); end
      if (valid_o !== 1'b1)        begin errors++; $display("FAIL stall_valid got=%b exp=1 c=%0d", valid_o, c); end
      if (result_o !== e0[16:0])   begin errors++; $display("FAIL stall_hold got=%h exp=%h c=%0d", result_o, e0[16:0], c); end
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    send(16'h7777, 16'h8889, 1'b1, model(16'h7777, 16'h8889, 1'b1));
    valid_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_saturation();
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 65534; i++) send(16'h0000, 16'h0000, 1'b1, {1'b1, 17'h0000F});
    valid_i = 1'b0; wait_drain(); check_cnt("cnt_preload", 16'hFFFE);
    for (int i = 0; i < 3; i++) send(16'h0000, 16'h0000, 1'b1, {1'b1, 17'h0000F});
    valid_i = 1'b0; wait_drain(); check_cnt("cnt_saturate", 16'hFFFF);
  endtask

  task automatic test_clear_collision();
    ready_i = 1'b0;
    send(16'h0F0F, 16'h0F0F, 1'b1, {1'b1, 17'h01E10});
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 ready_i = 1'b1; clear_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL clear_xfer got=%b exp=1", valid_o); end
    @(posedge clk_i); #1 clear_i = 1'b0;
    check_cnt("cnt_clear_priority", 16'h0000);
  endtask

  task automatic test_async_reset();
    ready_i = 1'b1;
    send(16'h0000, 16'h0000, 1'b1, {1'b1, 17'h0000F});
    valid_i = 1'b0; wait_drain(); check_cnt("cnt_before_rst", 16'd1);
    send(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0));
    send(16'h3333, 16'h4444, 1'b1, model(16'h3333, 16'h4444, 1'b1));
    valid_i = 1'b0;
    #3 rst_i = 1'b1;
    #1;
    checks += 2;
    if (valid_o !== 1'b0)    begin errors++; $display("FAIL arst_valid got=%b exp=0", valid_o); end
    if (err_cnt_o !== 16'h0) begin errors++; $display("FAIL arst_cnt got=%h exp=0", err_cnt_o); end
    exp_q.delete();
    exp_cnt = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      checks += 2;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL arst_stale got=%b exp=0 c=%0d", valid_o, c); end
      if (ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1 c=%0d", ready_o, c); end
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_clear_collision();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
